// File: rtl/pixel_unpacker.sv
// pixel_unpacker: turns a packed 24-bit BGR byte stream (4 pixels per 3 words)
// into one pixel per handshake. It tracks x/y, flags sof/eol and records
// sticky framing errors.
module pixel_unpacker #(
  parameter int X_SIZE = 640,
  parameter int Y_SIZE = 480
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [31:0] in_stream_tdata,
  input  logic [3:0]  in_stream_tkeep,
  input  logic        in_stream_tlast,
  input  logic        in_stream_tuser,
  input  logic        in_stream_tvalid,
  output logic        in_stream_tready,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b,
  output logic        valid,
  input  logic        out_ready,
  output logic        sof,
  output logic        eol,
  input  logic        err_clear,
  output logic [1:0]  err_status
);

  localparam logic [9:0] X_LAST   = 10'(X_SIZE - 1);
  localparam logic [9:0] X_PENULT = 10'(X_SIZE - 2);
  localparam logic [8:0] Y_LAST   = 9'(Y_SIZE - 1);

  // State name = number of leftover bytes held in res_q.
  typedef enum logic [1:0] {RES0, RES1, RES2, RES3} state_t;

  state_t      state, state_nxt, eff_state;
  logic [23:0] res_q, res_nxt;     // byte 0 is the oldest stream byte
  logic        synced;
  logic        run;                // holds tready low until the first clock after reset
  logic [9:0]  x;                  // position of the next pixel to be emitted
  logic [8:0]  y;
  logic [9:0]  px;
  logic [8:0]  py;
  logic [7:0]  pb, pg, pr;
  logic        out_free, accept, proc, restart, at_origin, emit_res3, load;
  logic        exp_last, sof_err_set, eol_err_set;
  logic        tkeep_unused;

  // The protocol guarantees full words, so tkeep carries no information.
  assign tkeep_unused = ^in_stream_tkeep;

  assign out_free         = !valid || out_ready;
  assign in_stream_tready = run && (state != RES3) && out_free;
  assign accept           = in_stream_tvalid && in_stream_tready;
  // Words accepted before the first tuser are discarded.
  assign proc             = accept && (synced || in_stream_tuser);
  // A tuser word always restarts decoding at byte 0 of pixel (0,0).
  assign restart          = proc && in_stream_tuser;
  assign eff_state        = restart ? RES0 : state;
  assign at_origin        = (state == RES0) && (x == '0) && (y == '0);
  assign emit_res3        = (state == RES3) && out_free;
  assign load             = proc || emit_res3;
  assign px               = restart ? '0 : x;
  assign py               = restart ? '0 : y;

  // tlast belongs on the word that leaves the last pixel of the line buffered.
  assign exp_last    = (eff_state == RES2) && (x == X_PENULT);
  assign sof_err_set = proc && synced && (in_stream_tuser != at_origin);
  assign eol_err_set = proc && (in_stream_tlast != exp_last);

  // Byte steering: pick the pixel bytes and the new leftover bytes.
  always_comb begin
    state_nxt = state;
    res_nxt   = res_q;
    pb        = res_q[7:0];
    pg        = res_q[15:8];
    pr        = res_q[23:16];
    if (proc) begin
      case (eff_state)
        RES0: begin
          pb = in_stream_tdata[7:0];
          pg = in_stream_tdata[15:8];
          pr = in_stream_tdata[23:16];
          res_nxt   = {16'h0, in_stream_tdata[31:24]};
          state_nxt = RES1;
        end
        RES1: begin
          pb = res_q[7:0];
          pg = in_stream_tdata[7:0];
          pr = in_stream_tdata[15:8];
          res_nxt   = {8'h0, in_stream_tdata[31:16]};
          state_nxt = RES2;
        end
        RES2: begin
          pb = res_q[7:0];
          pg = res_q[15:8];
          pr = in_stream_tdata[7:0];
          res_nxt   = in_stream_tdata[31:8];
          state_nxt = RES3;
        end
        default: ;
      endcase
    end else if (emit_res3) begin
      res_nxt   = '0;
      state_nxt = RES0;
    end
  end

  // Residual state, sync tracking and the post-reset ready gate.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state  <= RES0;
      res_q  <= '0;
      synced <= 1'b0;
      run    <= 1'b0;
    end else begin
      run   <= 1'b1;
      state <= state_nxt;
      res_q <= res_nxt;
      if (proc) synced <= 1'b1;
    end
  end

  // Single registered output stage; it holds while the output is stalled.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      valid <= 1'b0;
      r     <= '0;
      g     <= '0;
      b     <= '0;
      sof   <= 1'b0;
      eol   <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      r     <= pr;
      g     <= pg;
      b     <= pb;
      sof   <= (px == '0) && (py == '0);
      eol   <= (px == X_LAST);
    end else if (out_ready) begin
      valid <= 1'b0;
    end
  end

  // Pixel counters advance once per emitted pixel.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      x <= '0;
      y <= '0;
    end else if (load) begin
      if (px == X_LAST) begin
        x <= '0;
        y <= (py == Y_LAST) ? '0 : py + 9'd1;
      end else begin
        x <= px + 10'd1;
        y <= py;
      end
    end
  end

  // Sticky error flags; a new error takes priority over a clear in the same cycle.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) err_status <= '0;
    else          err_status <= (err_clear ? 2'b00 : err_status) | {eol_err_set, sof_err_set};
  end

endmodule

// File: tb/tb_pixel_unpacker.sv
// Directed bench for pixel_unpacker on a small 8x4 frame.
module tb_pixel_unpacker;

  localparam int XS = 8;
  localparam int YS = 4;

  logic        aclk;
  logic        aresetn;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tlast, tuser, tvalid, tready;
  logic [7:0]  r, g, b;
  logic        valid, out_ready, sof, eol, err_clear;
  logic [1:0]  err_status;

  pixel_unpacker #(.X_SIZE(XS), .Y_SIZE(YS)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .in_stream_tdata(tdata), .in_stream_tkeep(tkeep), .in_stream_tlast(tlast),
    .in_stream_tuser(tuser), .in_stream_tvalid(tvalid), .in_stream_tready(tready),
    .r(r), .g(g), .b(b), .valid(valid), .out_ready(out_ready),
    .sof(sof), .eol(eol), .err_clear(err_clear), .err_status(err_status)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int          total = 0;
  int          passes = 0;
  int          cyc = 0;
  int          lowcnt = 0;
  int          rd = 0;
  logic [25:0] q[$];   // captured pixels: {b,g,r,sof,eol}

  // Capture every handshaken pixel and count tready-low cycles.
  always @(negedge aclk) begin
    if (aresetn && valid && out_ready) q.push_back({b, g, r, sof, eol});
    if (aresetn && !tready) lowcnt <= lowcnt + 1;
  end

  always @(posedge aclk) cyc <= cyc + 1;

  function automatic logic [25:0] pk(input logic [7:0] pb, pg, pr, input logic s, e);
    return {pb, pg, pr, s, e};
  endfunction

  // Stream bytes of line y: pixel x occupies bytes 3x..3x+2 as b,g,r.
  function automatic logic [7:0] byte_of(input int y, input int idx);
    logic [7:0] p;
    p = 8'(y * XS + idx / 3);
    case (idx % 3)
      0:       return p;
      1:       return p ^ 8'h55;
      default: return p ^ 8'hAA;
    endcase
  endfunction

  function automatic logic [31:0] word_of(input int y, input int k);
    return {byte_of(y, 4*k+3), byte_of(y, 4*k+2), byte_of(y, 4*k+1), byte_of(y, 4*k)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic pop_chk(input string tag, input logic [25:0] exp);
    chk({tag, "_avail"}, 64'(q.size() > rd), 64'd1);
    if (q.size() > rd) begin
      chk(tag, 64'(q[rd]), 64'(exp));
      rd++;
    end
  endtask

  // Present a word at posedge+1 and return #1 after the edge that accepts it.
  task automatic send(input logic [31:0] d, input logic u, input logic l);
    int n;
    tdata = d; tuser = u; tlast = l; tvalid = 1'b1;
    n = 0;
    @(negedge aclk);
    while (!tready && n < 100) begin
      @(negedge aclk);
      n++;
    end
    if (n >= 100) chk("send_timeout", 64'(tready), 64'd1);
    @(posedge aclk);
    #1;
    tvalid = 1'b0; tuser = 1'b0; tlast = 1'b0;
  endtask

  task automatic send_line(input int y, input logic u);
    for (int k = 0; k < XS*3/4; k++)
      send(word_of(y, k), (k == 0) ? u : 1'b0, k == XS*3/4 - 1);
  endtask

  task automatic check_line(input int y);
    logic [7:0] p;
    for (int x = 0; x < XS; x++) begin
      p = 8'(y * XS + x);
      pop_chk($sformatf("px_y%0d_x%0d", y, x),
              pk(p, p ^ 8'h55, p ^ 8'hAA, (x == 0) && (y == 0), x == XS-1));
    end
  endtask

  task automatic drain(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  initial begin
    int l0, c0;
    aresetn = 1'b0; tdata = '0; tkeep = 4'hF; tlast = 1'b0; tuser = 1'b0;
    tvalid = 1'b0; out_ready = 1'b1; err_clear = 1'b0;

    // Reset state
    #12;
    chk("rst_tready", 64'(tready), 64'd0);
    chk("rst_valid",  64'(valid), 64'd0);
    chk("rst_pixel",  64'({r, g, b, sof, eol}), 64'd0);
    chk("rst_err",    64'(err_status), 64'd0);
    @(posedge aclk); #1;
    aresetn = 1'b1;

    // Words before any tuser are swallowed
    send(32'hDEADBEEF, 1'b0, 1'b0);
    send(32'h01020304, 1'b0, 1'b1);
    drain(3);
    chk("unsync_valid",   64'(valid), 64'd0);
    chk("unsync_npix",    64'(q.size()), 64'd0);
    chk("unsync_err",     64'(err_status), 64'd0);

    // First three words of a frame: four pixels, one tready bubble
    l0 = lowcnt;
    send(32'h44332211, 1'b1, 1'b0);
    send(32'h88776655, 1'b0, 1'b0);
    send(32'hCCBBAA99, 1'b0, 1'b0);
    drain(5);
    chk("res3_bubble", 64'(lowcnt - l0), 64'd1);
    pop_chk("w_p0", pk(8'h11, 8'h22, 8'h33, 1'b1, 1'b0));
    pop_chk("w_p1", pk(8'h44, 8'h55, 8'h66, 1'b0, 1'b0));
    pop_chk("w_p2", pk(8'h77, 8'h88, 8'h99, 1'b0, 1'b0));
    pop_chk("w_p3", pk(8'hAA, 8'hBB, 8'hCC, 1'b0, 1'b0));
    send(32'h0F0E0D0C, 1'b0, 1'b0);
    send(32'h13121110, 1'b0, 1'b0);
    send(32'h17161514, 1'b0, 1'b1);
    drain(4);
    pop_chk("w_p4", pk(8'h0C, 8'h0D, 8'h0E, 1'b0, 1'b0));
    pop_chk("w_p5", pk(8'h0F, 8'h10, 8'h11, 1'b0, 1'b0));
    pop_chk("w_p6", pk(8'h12, 8'h13, 8'h14, 1'b0, 1'b0));
    pop_chk("w_p7", pk(8'h15, 8'h16, 8'h17, 1'b0, 1'b1));
    for (int y = 1; y < YS; y++) send_line(y, 1'b0);
    drain(4);
    for (int y = 1; y < YS; y++) check_line(y);
    chk("f1_err", 64'(err_status), 64'd0);

    // Full frame after wrap: correct pixels, no errors, 3 words per 4 cycles
    drain(5);
    c0 = cyc;
    for (int y = 0; y < YS; y++) send_line(y, y == 0);
    chk("f2_cycles", 64'(cyc - c0), 64'd31);
    drain(4);
    for (int y = 0; y < YS; y++) check_line(y);
    chk("f2_err", 64'(err_status), 64'd0);
    chk("f2_npix", 64'(q.size() - rd), 64'd0);

    // Backpressure: hold out_ready low for 10 cycles with the output full
    out_ready = 1'b0;
    send(word_of(0, 0), 1'b1, 1'b0);
    tdata = word_of(0, 1); tvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      chk($sformatf("hold_%0d", i), 64'({tready, valid, b, g, r, sof, eol}),
          64'({1'b0, 1'b1, 8'h00, 8'h55, 8'hAA, 1'b1, 1'b0}));
    end
    @(posedge aclk); #1;
    out_ready = 1'b1;
    for (int k = 1; k < XS*3/4; k++) send(word_of(0, k), 1'b0, k == XS*3/4 - 1);
    drain(4);
    check_line(0);
    chk("bp_npix", 64'(q.size() - rd), 64'd0);
    chk("bp_err",  64'(err_status), 64'd0);

    // Misplaced tuser, misplaced tlast, clear vs. new-error priority
    send(32'h03020100, 1'b0, 1'b0);
    send(32'h07060504, 1'b1, 1'b0);
    drain(3);
    chk("sof_err", 64'(err_status), 64'd1);
    pop_chk("e_p0", pk(8'h00, 8'h01, 8'h02, 1'b0, 1'b0));
    pop_chk("e_p1", pk(8'h04, 8'h05, 8'h06, 1'b1, 1'b0));
    err_clear = 1'b1;
    send(32'h0B0A0908, 1'b0, 1'b1);
    err_clear = 1'b0;
    drain(2);
    chk("eol_err_wins", 64'(err_status), 64'd2);
    pop_chk("e_p2", pk(8'h07, 8'h08, 8'h09, 1'b0, 1'b0));
    err_clear = 1'b1;
    drain(1);
    err_clear = 1'b0;
    chk("err_clear", 64'(err_status), 64'd0);

    // Reset mid-line with a stalled pixel and a fresh error pending
    out_ready = 1'b0;
    send(32'h0F0E0D0C, 1'b0, 1'b1);
    drain(1);
    chk("pre_rst_state", 64'({valid, b, g, r, err_status}),
        64'({1'b1, 8'h0A, 8'h0B, 8'h0C, 2'b10}));
    aresetn = 1'b0;
    #1;
    chk("mid_rst_out", 64'({tready, valid, r, g, b, sof, eol, err_status}), 64'd0);
    out_ready = 1'b1;
    drain(1);
    aresetn = 1'b1;
    send(32'h11111111, 1'b0, 1'b0);
    drain(3);
    chk("post_rst_npix", 64'(q.size() - rd), 64'd0);
    send(32'h00302010, 1'b1, 1'b0);
    drain(3);
    pop_chk("resync_p0", pk(8'h10, 8'h20, 8'h30, 1'b1, 1'b0));
    chk("resync_err", 64'(err_status), 64'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
